pattern_serial_checker: RTL and testbench

- Downstream consumer of the 16-word pattern ROM (8-bit words).
- On START, walks the ROM addresses 0..15 and serialises each word MSB-first.
- Compares each serialised bit against the serial input X and reports pass/fail plus a mismatch count.
- Word and bit positions are tracked with a 4-bit word counter and a 3-bit bit counter.

---
 rtl/pchk_pkg.sv | 16 +
 rtl/pchk_shifter.sv | 46 ++++
 rtl/pattern_serial_checker.sv | 118 +++++++++++
 tb/tb_pattern_serial_checker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pchk_pkg.sv
// rtl/pchk_pkg.sv - shared states and default widths for the pattern serial checker
package pchk_pkg;

   localparam int AW_DEF = 4;
   localparam int DW_DEF = 8;
   localparam int EW_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SHIFT,
      DONE
   } state_e;

endpackage

// File: rtl/pchk_shifter.sv
// rtl/pchk_shifter.sv - load/shift-left word register with MSB out and down-counting bit index
module pchk_shifter #(
   parameter int DW = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_i,
   input  logic          shift_i,
   input  logic [DW-1:0] data_i,
   output logic          msb_o,
   output logic          last_o
);

   localparam int BW = $clog2(DW);

   logic [DW-1:0] sreg_q, sreg_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;

   // Load takes priority; a shift consumes the MSB and steps the bit index down.
   always_comb begin
      sreg_d    = sreg_q;
      bit_cnt_d = bit_cnt_q;
      if (load_i) begin
         sreg_d    = data_i;
         bit_cnt_d = BW'(DW - 1);
      end else if (shift_i) begin
         sreg_d    = {sreg_q[DW-2:0], 1'b0};
         bit_cnt_d = bit_cnt_q - BW'(1);
      end
   end

   // Word register and bit index.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sreg_q    <= '0;
         bit_cnt_q <= '0;
      end else begin
         sreg_q    <= sreg_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign msb_o  = sreg_q[DW-1];
   assign last_o = (bit_cnt_q == '0);

endmodule

// File: rtl/pattern_serial_checker.sv
// rtl/pattern_serial_checker.sv - walks the pattern ROM and checks serial X MSB-first (PCHK_EARLY_ABORT_EN: stop at first mismatch)
module pattern_serial_checker
   import pchk_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF,
   parameter int EW = EW_DEF
) (
   input  logic          CLK,
   input  logic          CLR_N,
   input  logic          START,
   input  logic          X,
   input  logic          X_VALID,
   output logic [AW-1:0] ADDR,
   input  logic [DW-1:0] DATA,
   output logic          BUSY,
   output logic          G,
   output logic          Z,
   output logic [EW-1:0] ERR_CNT
);

   state_e        state_q, state_d;
   logic [AW-1:0] word_q, word_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [EW-1:0] err_q, err_d;
   logic          g_q, g_d;
   logic          load, shift, msb, last, mism, abort;

   pchk_shifter #(.DW(DW)) u_shifter (
      .clk_i   (CLK),
      .rst_ni  (CLR_N),
      .load_i  (load),
      .shift_i (shift),
      .data_i  (DATA),
      .msb_o   (msb),
      .last_o  (last)
   );

   // Next state: ADDR is set on entry to FETCH so the registered ROM data is ready in LOAD.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      addr_d  = addr_q;
      err_d   = err_q;
      g_d     = g_q;
      load    = 1'b0;
      shift   = 1'b0;
      mism    = X ^ msb;
      abort   = 1'b0;
`ifdef PCHK_EARLY_ABORT_EN
      abort   = mism;
`endif
      case (state_q)
         IDLE: begin
            if (START) begin
               state_d = FETCH;
               word_d  = '0;
               addr_d  = '0;
               err_d   = '0;
               g_d     = 1'b0;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            load    = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (X_VALID) begin
               shift = 1'b1;
               if (mism) begin
                  err_d = err_q + EW'(1);
               end
               if (abort) begin
                  state_d = DONE;
               end else if (last) begin
                  if (word_q == '1) begin
                     state_d = DONE;
                  end else begin
                     word_d  = word_q + AW'(1);
                     addr_d  = word_q + AW'(1);
                     state_d = FETCH;
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_q == SHIFT && state_d == DONE) begin
         g_d = (err_d == '0);
      end
   end

   // Control and result registers.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q <= IDLE;
         word_q  <= '0;
         addr_q  <= '0;
         err_q   <= '0;
         g_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         g_q     <= g_d;
      end
   end

   assign ADDR    = addr_q;
   assign BUSY    = (state_q != IDLE);
   assign Z       = (state_q == DONE);
   assign G       = g_q;
   assign ERR_CNT = err_q;

endmodule

// File: tb/tb_pattern_serial_checker.sv
// tb/tb_pattern_serial_checker.sv - scoreboard bench for pattern_serial_checker
module tb_pattern_serial_checker;

   logic       CLK = 1'b0;
   logic       CLR_N = 1'b0;
   logic       START = 1'b0;
   logic       X = 1'b0;
   logic       X_VALID = 1'b0;
   logic [3:0] ADDR;
   logic [7:0] DATA = 8'h00;
   logic       BUSY, G, Z;
   logic [7:0] ERR_CNT;

   logic [7:0] rom [16];
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;

   typedef struct {
      int   start;
      int   lat;
      logic g;
      int   err;
      int   addr;
   } exp_t;

   exp_t sbq[$];
   exp_t cur;
   logic post_z = 1'b0;

   pattern_serial_checker dut (
      .CLK     (CLK),
      .CLR_N   (CLR_N),
      .START   (START),
      .X       (X),
      .X_VALID (X_VALID),
      .ADDR    (ADDR),
      .DATA    (DATA),
      .BUSY    (BUSY),
      .G       (G),
      .Z       (Z),
      .ERR_CNT (ERR_CNT)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) DATA <= rom[ADDR];
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (post_z) begin
         post_z = 1'b0;
         chk("z_one_cycle", int'(Z), 0);
         chk("g_held", int'(G), int'(cur.g));
         chk("idle_after_done", int'(BUSY), 0);
      end
      if (CLR_N && Z === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_z", 1, 0);
         end else begin
            cur = sbq.pop_front();
            chk("latency", cyc - cur.start, cur.lat);
            chk("g", int'(G), int'(cur.g));
            chk("err_cnt", int'(ERR_CNT), cur.err);
            chk("addr_at_done", int'(ADDR), cur.addr);
            post_z = 1'b1;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         START   = 1'b0;
         X_VALID = 1'b0;
      end
   endtask

   task automatic do_run(input int stall, input bit zeros,
                         input int e0w, input int e0b, input int e1w, input int e1b,
                         input int sp_w, input int sp_err, input int rst_w, input bit pre,
                         input int lat, input logic g, input int err, input int addr);
      exp_t e;
      logic v;
      if (pre) begin
         @(negedge CLK);
         START   = 1'b1;
         X_VALID = 1'b0;
      end
      @(negedge CLK);
      START   = 1'b1;
      X_VALID = 1'b0;
      if (rst_w < 0) begin
         e.start = cyc;
         e.lat   = lat;
         e.g     = g;
         e.err   = err;
         e.addr  = addr;
         sbq.push_back(e);
      end
      for (int w = 0; w < 16; w++) begin
         for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            START   = 1'b0;
            X_VALID = 1'b1;
            X       = ~rom[w][7];
         end
         for (int b = 7; b >= 0; b--) begin
            v = zeros ? 1'b0 : rom[w][b];
            if ((w == e0w && b == e0b) || (w == e1w && b == e1b)) v = ~v;
            repeat (stall) begin
               @(negedge CLK);
               START   = 1'b0;
               X_VALID = 1'b0;
               X       = ~v;
            end
            @(negedge CLK);
            if (w == sp_w && b == 3) begin
               chk("midrun_start_err_kept", int'(ERR_CNT), sp_err);
               chk("midrun_start_busy", int'(BUSY), 1);
               chk("midrun_start_addr", int'(ADDR), sp_w);
            end
            START   = (w == sp_w && b == 4);
            X_VALID = 1'b1;
            X       = v;
            if (w == rst_w && b == 7) begin
               CLR_N   = 1'b0;
               START   = 1'b0;
               X_VALID = 1'b0;
               #1;
               chk("rst_busy", int'(BUSY), 0);
               chk("rst_err_cnt", int'(ERR_CNT), 0);
               chk("rst_z", int'(Z), 0);
               chk("rst_g", int'(G), 0);
               chk("rst_addr", int'(ADDR), 0);
               @(negedge CLK);
               CLR_N = 1'b1;
               return;
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = i[0] ? 8'hAA : 8'hCC;
      repeat (3) @(negedge CLK);
      chk("reset_busy", int'(BUSY), 0);
      chk("reset_z", int'(Z), 0);
      chk("reset_g", int'(G), 0);
      chk("reset_err_cnt", int'(ERR_CNT), 0);
      chk("reset_addr", int'(ADDR), 0);
      CLR_N = 1'b1;
      idle(2);

      // clean run, then a START held across DONE and the following IDLE cycle
      do_run(0, 0, -1, -1, -1, -1, -1, 0, -1, 0, 161, 1'b1, 0, 15);
      do_run(0, 0, -1, -1, -1, -1, -1, 0, -1, 1, 161, 1'b1, 0, 15);
      idle(3);
`ifdef PCHK_EARLY_ABORT_EN
      do_run(0, 0, 5, 3, -1, -1, -1, 0, -1, 0, 58, 1'b0, 1, 5);
      idle(3);
      do_run(0, 1, -1, -1, -1, -1, -1, 0, -1, 0, 4, 1'b0, 1, 0);
      idle(3);
      do_run(3, 0, -1, -1, -1, -1, -1, 0, -1, 0, 545, 1'b1, 0, 15);
      idle(3);
      do_run(0, 0, 12, 0, -1, -1, 8, 0, -1, 0, 131, 1'b0, 1, 12);
      idle(3);
      do_run(0, 0, -1, -1, -1, -1, -1, 0, 7, 0, 0, 1'b0, 0, 0);
`else
      do_run(0, 0, 5, 3, -1, -1, -1, 0, -1, 0, 161, 1'b0, 1, 15);
      idle(3);
      do_run(0, 1, -1, -1, -1, -1, -1, 0, -1, 0, 161, 1'b0, 64, 15);
      idle(3);
      do_run(3, 0, -1, -1, -1, -1, -1, 0, -1, 0, 545, 1'b1, 0, 15);
      idle(3);
      do_run(0, 0, 2, 6, 12, 0, 8, 1, -1, 0, 161, 1'b0, 2, 15);
      idle(3);
      do_run(0, 0, 1, 7, -1, -1, -1, 0, 7, 0, 0, 1'b0, 0, 0);
`endif
      idle(3);
      do_run(0, 0, -1, -1, -1, -1, -1, 0, -1, 0, 161, 1'b1, 0, 15);

      for (int t = 0; t < 200 && sbq.size() != 0; t++) @(negedge CLK);
      idle(2);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
